div_ctrl: RTL and testbench

Sequencer and HI/LO holding stage that sits between the control unit and the multicycle signed divider.
- Takes a one-cycle divide request and registers the operands.
- Issues the divider start strobe and checks the divider's divide-by-zero flag.
- Waits for the divider's done flag, then commits quotient/remainder into architectural LO/HI.
- LO/HI stay stable for mflo/mfhi until the next commit or mtlo/mthi.
- Gives the control unit busy/done/exception signals, so it does not need to track the divider's 32-cycle timing.

---
 rtl/div_ctrl_pkg.sv | 14 +
 rtl/div_ctrl_if.sv | 41 ++++
 rtl/div_ctrl_hilo_regs.sv | 31 +++
 rtl/div_ctrl.sv | 107 ++++++++++
 tb/tb_div_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the divider sequencer and HI/LO stage.
package div_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DIV_LATENCY   = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CHECK,
        WAIT
    } state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// Control-unit and divider-facing signal bundle for div_ctrl.
interface div_ctrl_if import div_ctrl_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
);
    // Control unit side
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Divider side
    logic [WIDTH-1:0] div_hi_in;
    logic [WIDTH-1:0] div_lo_in;
    logic             div_stop_in;
    logic             div_zero_in;
    logic             div_control;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;

    modport master (
        output start, op_a, op_b, wr_hi, wr_lo, wdata,
        output div_hi_in, div_lo_in, div_stop_in, div_zero_in,
        input  busy, done, div_by_zero, hi, lo,
        input  div_control, div_a, div_b
    );

    modport slave (
        input  start, op_a, op_b, wr_hi, wr_lo, wdata,
        input  div_hi_in, div_lo_in, div_stop_in, div_zero_in,
        output busy, done, div_by_zero, hi, lo,
        output div_control, div_a, div_b
    );

endinterface

// File: rtl/div_ctrl_hilo_regs.sv
// Architectural HI/LO pair: divider commit has priority, otherwise mthi/mtlo writes.
module div_ctrl_hilo_regs import div_ctrl_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= hi_in;
            lo <= lo_in;
        end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer: operand capture, start strobe, zero check, result commit to HI/LO.
// Optional watchdog in WAIT enabled by defining DIV_CTRL_WATCHDOG_EN.
module div_ctrl import div_ctrl_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
`ifdef DIV_CTRL_WATCHDOG_EN
    , parameter int MAX_CYCLES = DIV_LATENCY + 8
`endif
) (
    input  logic      clk,
    input  logic      reset,
    div_ctrl_if.slave bus
);

    state_t state;
    logic   commit;
    logic   wr_hi_en;
    logic   wr_lo_en;
    logic   wd_expired;

    // Register writes only land in IDLE without a competing start, so a commit never races them.
    assign commit   = (state == WAIT) && bus.div_stop_in;
    assign wr_hi_en = (state == IDLE) && !bus.start && bus.wr_hi;
    assign wr_lo_en = (state == IDLE) && !bus.start && bus.wr_lo;

`ifdef DIV_CTRL_WATCHDOG_EN
    localparam int CW = $clog2(MAX_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == WAIT && !bus.div_stop_in) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = (wd_cnt == CW'(MAX_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bus.div_control <= 1'b0;
            bus.div_a       <= '0;
            bus.div_b       <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the branch that fires raises them.
            bus.div_control <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.div_a       <= bus.op_a;
                        bus.div_b       <= bus.op_b;
                        bus.busy        <= 1'b1;
                        bus.div_control <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: state <= CHECK;
                CHECK: begin
                    if (bus.div_zero_in) begin
                        bus.div_by_zero <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.div_stop_in) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (wd_expired) begin
                        bus.div_by_zero <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    div_ctrl_hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clk   (clk),
        .reset (reset),
        .commit(commit),
        .wr_hi (wr_hi_en),
        .wr_lo (wr_lo_en),
        .wdata (bus.wdata),
        .hi_in (bus.div_hi_in),
        .lo_in (bus.div_lo_in),
        .hi    (bus.hi),
        .lo    (bus.lo)
    );

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 32-cycle signed divider stub.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int W       = 32;
    localparam int MAX_CYC = 40;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    div_ctrl_if #(.WIDTH(W)) bus ();

    div_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Divider stub: samples the strobe, clears stop, flags zero, raises stop 31 edges later.
    logic [W-1:0] stub_q, stub_r;
    logic         stub_stop, stub_zero;
    int           stub_cnt;
    logic         hang       = 1'b0;
    logic         force_stop = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stub_stop <= 1'b0;
            stub_zero <= 1'b0;
            stub_cnt  <= 0;
            stub_q    <= '0;
            stub_r    <= '0;
        end else if (bus.div_control) begin
            stub_stop <= 1'b0;
            stub_zero <= (bus.div_b == '0);
            stub_cnt  <= 1;
            if (bus.div_b != '0) begin
                stub_q <= $signed(bus.div_a) / $signed(bus.div_b);
                stub_r <= $signed(bus.div_a) % $signed(bus.div_b);
            end
        end else if (stub_cnt != 0) begin
            if (stub_cnt == DIV_LATENCY - 1) begin
                stub_cnt  <= 0;
                stub_stop <= !hang;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    assign bus.div_stop_in = stub_stop | force_stop;
    assign bus.div_zero_in = stub_zero;
    assign bus.div_hi_in   = stub_r;
    assign bus.div_lo_in   = stub_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at edge n, then walk to the done cycle (after edge n+33) checking timing.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                           input string name);
        int bad;
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
        tick();
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
        checks++;
        if (bus.div_control !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s issue: div_control=%b busy=%b, want 1 1", name, bus.div_control, bus.busy);
        end
        checks++;
        if (bus.div_a !== a || bus.div_b !== b) begin
            errors++;
            $display("FAIL %s operands: div_a=%h div_b=%h, want %h %h", name, bus.div_a, bus.div_b, a, b);
        end
        tick();
        checks++;
        if (bus.div_control !== 1'b0) begin
            errors++;
            $display("FAIL %s strobe_width: div_control=%b, want 0", name, bus.div_control);
        end
        bad = 0;
        for (int k = 2; k <= 32; k++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s wait_phase: %0d bad cycles, want 0", name, bad);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b busy=%b, want 1 0", name, bus.done, bus.busy);
        end
        checks++;
        if (bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL %s lo: got %h, want %h", name, bus.lo, exp_lo);
        end
        checks++;
        if (bus.hi !== exp_hi) begin
            errors++;
            $display("FAIL %s hi: got %h, want %h", name, bus.hi, exp_hi);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.div_control, bus.div_a, bus.div_b, bus.busy, bus.done,
             bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dc=%b a=%h b=%h busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     bus.div_control, bus.div_a, bus.div_b, bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_mt();
        bus.wr_hi = 1'b1; bus.wdata = 32'hAAAA5555;
        tick();
        bus.wr_hi = 1'b0;
        checks++;
        if (bus.hi !== 32'hAAAA5555 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h, want aaaa5555 00000000", bus.hi, bus.lo);
        end
        bus.wr_lo = 1'b1; bus.wdata = 32'h12345678;
        tick();
        bus.wr_lo = 1'b0;
        checks++;
        if (bus.lo !== 32'h12345678 || bus.hi !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h, want aaaa5555 12345678", bus.hi, bus.lo);
        end
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h0F0F0F0F;
        tick();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        checks++;
        if (bus.hi !== 32'h0F0F0F0F || bus.lo !== 32'h0F0F0F0F) begin
            errors++;
            $display("FAIL mt_both: hi=%h lo=%h, want 0f0f0f0f 0f0f0f0f", bus.hi, bus.lo);
        end
    endtask

    task automatic test_basic();
        run_div(32'd100, 32'd7, 32'd14, 32'd2, "div_100_7");
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++;
            $display("FAIL after_done: done=%b lo=%h hi=%h, want 0 0000000e 00000002", bus.done, bus.lo, bus.hi);
        end
    endtask

    task automatic test_signed();
        run_div(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2");
    endtask

    task automatic test_zero();
        int bad;
        bus.start = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd0;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.div_control !== 1'b1) begin
            errors++;
            $display("FAIL zero_issue: div_control=%b, want 1", bus.div_control);
        end
        tick();
        checks++;
        if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_check_cycle: dz=%b busy=%b, want 0 1", bus.div_by_zero, bus.busy);
        end
        tick();
        checks++;
        if (bus.div_by_zero !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: dz=%b busy=%b done=%b, want 1 0 0", bus.div_by_zero, bus.busy, bus.done);
        end
        bad = 0;
        for (int k = 0; k < 36; k++) begin
            tick();
            if (bus.div_by_zero !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_aftermath: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL zero_hilo: hi=%h lo=%h, want ffffffff fffffffd", bus.hi, bus.lo);
        end
    endtask

    task automatic test_busy_ignore();
        bus.start = 1'b1; bus.op_a = 32'd20; bus.op_b = 32'd6;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1; bus.op_a = 32'd1000; bus.op_b = 32'd1;
        bus.wr_hi = 1'b1; bus.wdata = 32'hDEADBEEF;
        tick();
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        checks++;
        if (bus.div_a !== 32'd20 || bus.div_b !== 32'd6 || bus.div_control !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: div_a=%h div_b=%h dc=%b, want 00000014 00000006 0",
                     bus.div_a, bus.div_b, bus.div_control);
        end
        checks++;
        if (bus.hi !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL busy_mthi: hi=%h, want ffffffff", bus.hi);
        end
        repeat (28) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.lo !== 32'd3 || bus.hi !== 32'd2) begin
            errors++;
            $display("FAIL busy_result: done=%b lo=%h hi=%h, want 1 00000003 00000002", bus.done, bus.lo, bus.hi);
        end
        // Start accepted in the done cycle.
        run_div(32'd50, 32'hFFFFFFF8, 32'hFFFFFFFA, 32'd2, "back_to_back");
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.op_a = 32'd77; bus.op_b = 32'd5;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset: hi=%h lo=%h busy=%b state=%0d, want 0 0 0 0",
                     bus.hi, bus.lo, bus.busy, dut.state);
        end
        #3 reset = 1'b1;
        tick();
        run_div(32'd9, 32'd3, 32'd3, 32'd0, "div_9_3");
        tick();
    endtask

    task automatic test_hang();
        int bad;
        hang = 1'b1;
        bus.start = 1'b1; bus.op_a = 32'd40; bus.op_b = 32'd3;
        tick();
        bus.start = 1'b0;
`ifdef DIV_CTRL_WATCHDOG_EN
        bad = 0;
        for (int k = 1; k <= MAX_CYC + 1; k++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.div_by_zero !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wd_early: %0d bad cycles, want 0", bad);
        end
        tick();
        checks++;
        if (bus.div_by_zero !== 1'b1 || bus.busy !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL wd_fault: dz=%b busy=%b state=%0d, want 1 0 0", bus.div_by_zero, bus.busy, dut.state);
        end
        checks++;
        if (bus.lo !== 32'd3 || bus.hi !== 32'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL wd_hilo: lo=%h hi=%h done=%b, want 00000003 00000000 0", bus.lo, bus.hi, bus.done);
        end
`else
        bad = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.div_by_zero !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_wait: %0d bad cycles, want 0", bad);
        end
        force_stop = 1'b1;
        tick();
        force_stop = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.lo !== 32'd13 || bus.hi !== 32'd1) begin
            errors++;
            $display("FAIL late_stop: done=%b lo=%h hi=%h, want 1 0000000d 00000001", bus.done, bus.lo, bus.hi);
        end
`endif
        hang = 1'b0;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_mt();
        test_basic();
        test_signed();
        test_zero();
        test_busy_ignore();
        test_reset_mid();
        test_hang();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
